// File: rtl/fetch_unit.sv
// fetch_unit: three-state instruction fetch with jump/branch next-pc selection
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        Jump,
   input  logic        Branch,
   input  logic        zero,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] retired
);
   typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
   localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};
   state_t state, state_next;
   logic take, accept;
   logic [31:0] br_off, pc_next;
   // state register; reset lands in IDLE so one settling cycle precedes the first request
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_next;
   // next state, handshakes and next-pc selection (Jump outranks Branch)
   always_comb begin
      take = state == FETCH && imem_ack;
      accept = state == ISSUE && inst_ready;
      state_next = state == IDLE ? FETCH : take ? ISSUE : accept ? FETCH : state;
      br_off = {{14{inst[15]}}, inst[15:0], 2'b00};
      pc_next = Jump ? {pc_plus4[31:28], inst[25:0], 2'b00} :
                (Branch && zero) ? pc_plus4 + br_off : pc_plus4;
   end
   // instruction latch, pc update and retire counter
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pc <= START_PC;
         inst <= '0;
         retired <= '0;
      end else begin
         if (take) inst <= imem_rdata;
         if (accept) begin
            pc <= pc_next;
            retired <= retired + 32'd1;
         end
      end
   assign pc_plus4 = pc + 32'd4;
   assign imem_req = state == FETCH;
   assign imem_addr = pc;
   assign inst_valid = state == ISSUE;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench with a next-pc reference model
module tb_fetch_unit;
   logic clk = 0, rst = 1, imem_ack = 0, inst_ready = 0, Jump = 0, Branch = 0, zero = 0;
   logic [31:0] imem_rdata = 0;
   logic imem_req, inst_valid;
   logic [31:0] imem_addr, inst, pc, pc_plus4, retired;
   logic [31:0] model_pc = 0, model_ret = 0;
   int n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .Jump(Jump), .Branch(Branch), .zero(zero),
      .pc(pc), .pc_plus4(pc_plus4), .retired(retired)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic noise;
      Jump = 1'($urandom);
      Branch = 1'($urandom);
      zero = 1'($urandom);
   endtask

   task automatic do_instr(input logic [31:0] w, input int ack_dly, input int rdy_dly,
                           input logic j, input logic b, input logic z);
      int nv = 0;
      int off;
      logic [31:0] nxt;
      chk("req", 32'(imem_req), 1);
      chk("addr", imem_addr, model_pc);
      for (int i = 0; i < ack_dly; i++) begin
         imem_ack = 0;
         inst_ready = 1'($urandom);
         noise();
         step();
         chk("req_hold", 32'(imem_req), 1);
         chk("addr_hold", imem_addr, model_pc);
         chk("ret_fetch", retired, model_ret);
      end
      imem_ack = 1;
      imem_rdata = w;
      inst_ready = 0;
      step();
      imem_ack = 0;
      chk("inst", inst, w);
      chk("pc", pc, model_pc);
      chk("pc_plus4", pc_plus4, model_pc + 32'd4);
      chk("req_issue", 32'(imem_req), 0);
      for (int i = 0; i < rdy_dly; i++) begin
         nv += int'(inst_valid);
         imem_ack = 1'($urandom);
         imem_rdata = $urandom;
         noise();
         step();
         chk("inst_hold", inst, w);
         chk("pc_hold", pc, model_pc);
      end
      nv += int'(inst_valid);
      imem_ack = 0;
      inst_ready = 1;
      Jump = j;
      Branch = b;
      zero = z;
      step();
      inst_ready = 0;
      noise();
      if (j) nxt = ((model_pc + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
      else if (b && z) begin
         off = int'($signed(w[15:0]));
         nxt = model_pc + 32'd4 + 32'(off * 4);
      end else nxt = model_pc + 32'd4;
      model_pc = nxt;
      model_ret = model_ret + 32'd1;
      chk("valid_cycles", 32'(nv), 32'(rdy_dly + 1));
      chk("valid_after", 32'(inst_valid), 0);
      chk("next_addr", imem_addr, model_pc);
      chk("retired", retired, model_ret);
   endtask

   task automatic reset_pulse;
      #2 rst = 1;
      #1;
      chk("rst_req", 32'(imem_req), 0);
      chk("rst_valid", 32'(inst_valid), 0);
      chk("rst_pc", pc, 0);
      chk("rst_inst", inst, 0);
      chk("rst_ret", retired, 0);
      @(negedge clk);
      rst = 0;
      imem_ack = 1;
      imem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("idle_req", 32'(imem_req), 0);
      step();
      imem_ack = 0;
      chk("post_idle_req", 32'(imem_req), 1);
      chk("post_idle_addr", imem_addr, 0);
      chk("post_idle_valid", 32'(inst_valid), 0);
      step();
      chk("late_ack_valid", 32'(inst_valid), 0);
      chk("late_ack_inst", inst, 0);
      model_pc = 0;
      model_ret = 0;
   endtask

   initial begin
      #1;
      chk("init_req", 32'(imem_req), 0);
      chk("init_valid", 32'(inst_valid), 0);
      chk("init_pc", pc, 0);
      chk("init_pc4", pc_plus4, 32'd4);
      chk("init_ret", retired, 0);
      @(negedge clk);
      rst = 0;
      #1;
      chk("idle_req0", 32'(imem_req), 0);
      step();
      chk("first_req", 32'(imem_req), 1);
      repeat (4) do_instr($urandom & 32'h03FF_FFFF, 1, 0, 0, 0, 0);
      chk("seq_ret4", retired, 32'd4);
      chk("seq_addr", imem_addr, 32'h10);
      do_instr(32'h0810_0004, 0, 0, 1, 0, 0);
      chk("jump_setup", imem_addr, 32'h0040_0010);
      do_instr(32'h0810_0000, 0, 0, 1, 0, 0);
      chk("jump_tgt", imem_addr, 32'h0040_0000);
      do_instr(32'h0800_0040, 0, 1, 1, 0, 0);
      do_instr(32'h1000_FFFE, 0, 0, 0, 1, 1);
      chk("branch_taken", imem_addr, 32'hFC);
      do_instr(32'h0800_0040, 0, 0, 1, 0, 0);
      do_instr(32'h1000_FFFE, 0, 0, 0, 1, 0);
      chk("branch_not", imem_addr, 32'h104);
      do_instr(32'h0800_0040, 0, 0, 1, 1, 1);
      chk("jump_prio", imem_addr, 32'h100);
      do_instr($urandom, 5, 3, 0, 0, 0);
      do_instr(32'h0800_0000, 0, 0, 1, 0, 0);
      do_instr(32'h1000_FFFE, 0, 0, 0, 1, 1);
      chk("wrap_pc", imem_addr, 32'hFFFF_FFFC);
      do_instr($urandom & 32'h03FF_FFFF, 0, 0, 0, 0, 0);
      chk("wrap_next", imem_addr, 0);
      step();
      reset_pulse();
      do_instr($urandom, 1, 0, 0, 0, 0);
      for (int k = 0; k < 40; k++)
         do_instr($urandom, $urandom_range(3), $urandom_range(3),
                  1'($urandom), 1'($urandom), 1'($urandom));
      imem_ack = 1;
      step();
      imem_ack = 0;
      chk("pre_rst_issue", 32'(inst_valid), 1);
      reset_pulse();
      do_instr($urandom, 2, 1, 0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first instruction address after reset.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: imem_req  out  1  instruction-memory read request; imem_addr  out  32  byte address of request.
REQ-005 SHALL have ports: imem_ack  in  1  read data valid this cycle; imem_rdata  in  32  instruction word.
REQ-006 SHALL have ports: inst  out  32  held instruction, where inst[31:26] drives the main control decoder; inst_valid  out  1  inst is valid.
REQ-007 SHALL have ports: inst_ready  in  1  datapath completes the current instruction this cycle.
REQ-008 SHALL have ports: Jump  in  1; Branch  in  1; zero  in  1 (ALU equal flag), all from the decoder and datapath for the held inst.
REQ-009 SHALL have ports: pc  out  32  address of held or requested instruction; pc_plus4  out  32  pc+4; retired  out  32  count of completed instructions.

Function
REQ-010 SHALL implement the FSM states IDLE, FETCH and ISSUE.
REQ-011 IDLE SHALL last exactly one cycle after reset deassertion and SHALL then go to FETCH; outputs SHALL hold their reset values while in IDLE.
REQ-012 In FETCH: imem_req=1, imem_addr=pc, both stable until imem_ack is seen.
REQ-013 On imem_ack in FETCH at cycle N: inst<=imem_rdata and the FSM goes to ISSUE; inst_valid=1 and imem_req=0 from cycle N+1.
REQ-014 imem_ack SHALL be ignored in IDLE and ISSUE.
REQ-015 In ISSUE: inst, pc and inst_valid SHALL be held until inst_ready=1.
REQ-016 On inst_ready in ISSUE at cycle M, the next pc SHALL be selected with Jump, Branch and zero sampled in cycle M only.
REQ-017 Next pc when Jump=1: {pc_plus4[31:28], inst[25:0], 2'b00}. Jump SHALL have priority over Branch.
REQ-018 Next pc when Branch=1 and zero=1: pc_plus4 + (sign-extended inst[15:0] << 2), modulo 2^32.
REQ-019 Next pc otherwise, including Branch=1 with zero=0: pc_plus4.
REQ-020 On inst_ready in ISSUE: retired increments by 1 and wraps from 32'hFFFF_FFFF to 0; inst_valid=0 and imem_req=1 with the new pc from cycle M+1 (FETCH).
REQ-021 inst_ready SHALL be ignored outside ISSUE.
REQ-022 pc_plus4 SHALL be pc+4 combinationally, modulo 2^32: pc=32'hFFFF_FFFC gives pc_plus4=0, and sequential fetch continues from 0.
REQ-023 pc[1:0] SHALL always be 2'b00. RESET_PC[1:0] SHALL be forced to 0.
REQ-024 A fetch response taking one or more cycles SHALL need no other stimulus than holding imem_ack low; a request has no timeout.

Reset
REQ-025 Asynchronous assertion of rst SHALL immediately set: state=IDLE, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, retired=0.
REQ-026 rst asserted mid-FETCH SHALL abandon the request, with imem_req falling without a clock edge. A late imem_ack after reset SHALL be ignored.
REQ-027 rst asserted mid-ISSUE SHALL discard the held instruction without incrementing retired.

Verification
REQ-028 Sequential: RESET_PC=0, ack 1 cycle after each req, inst_ready held 1, no Jump/Branch -> imem_addr sequence 0,4,8,C; retired=4 after the 4th accept.
REQ-029 Jump: pc=0x0040_0010, inst=32'h0810_0000, Jump=1 at accept -> next imem_addr=0x0040_0000.
REQ-030 Branch: pc=0x100, inst[15:0]=16'hFFFE, Branch=1, zero=1 -> next addr 0xFC. Same with zero=0 -> next addr 0x104. Jump=1 and Branch=1 together -> Jump target.
REQ-031 Stall: ack delayed 5 cycles, then inst_ready delayed 3 cycles -> imem_addr stable throughout, inst_valid=1 for exactly 4 cycles, retired increments once.
REQ-032 Wrap: pc=32'hFFFF_FFFC, plain instruction accepted -> next imem_addr=0. Retired preloaded to 32'hFFFF_FFFF via accepts -> 0.
REQ-033 Reset mid-FETCH with ack arriving 1 cycle after rst falls -> ack ignored, IDLE for one cycle, then request at RESET_PC; inst_valid stays 0.
